// File: rtl/irq_ctrl.sv
// Interrupt controller with a registered-address slave port, a fixed-priority selector and a claim/EOI FSM.
// Define IRQC_LEVEL_MODE_EN for level-sensitive sources; the default build latches rising edges.
//
// state   | meaning
// IDLE    | no interrupt presented to the CPU
// ASSERT  | irq_out high, waiting for a CLAIM read
// SERVICE | claimed source being serviced, waiting for matching EOI
module irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        haddr,
    input  logic [31:0]        hwdata,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic               hsel,
    output logic [31:0]        hrdata,
    output logic               hready,
    output logic [1:0]         hresp,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_out,
    output logic [2:0]         irq_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               ap_valid, ap_write;
    logic [2:0]         ap_addr;
    logic [NUM_SRC-1:0] pending, pending_nxt, enable, eligible;
    logic [2:0]         claimed_id, sel_id;
    logic               eoi_err, irq_out_q;
    logic               wr_en, rd_en, claim_ok, eoi_wr, eoi_match;
    logic               unused_bits;

    assign unused_bits = ^{hsize, haddr[31:5], haddr[1:0], hwdata};

    assign hready   = 1'b1;
    assign hresp    = 2'b00;
    assign eligible = pending & enable;

    always_comb begin
        sel_id = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = 3'(i);
        end
    end

    assign wr_en     = ap_valid & ap_write;
    assign rd_en     = ap_valid & ~ap_write;
    assign claim_ok  = rd_en && (ap_addr == 3'd2) && (state == ASSERT) && (|eligible);
    assign eoi_wr    = wr_en && (ap_addr == 3'd3);
    assign eoi_match = eoi_wr && (state == SERVICE) && (hwdata[2:0] == claimed_id);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|eligible) state_nxt = ASSERT;
            ASSERT: begin
                if (claim_ok)        state_nxt = SERVICE;
                else if (!(|eligible)) state_nxt = IDLE;
            end
            SERVICE: if (eoi_match) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef IRQC_LEVEL_MODE_EN
    always_comb begin
        pending_nxt = irq_src;
    end
`else
    logic [NUM_SRC-1:0] src_q, clr_mask;

    // set wins over W1C and claim clear in the same cycle
    always_comb begin
        clr_mask = '0;
        if (wr_en && (ap_addr == 3'd0)) clr_mask = hwdata[NUM_SRC-1:0];
        if (claim_ok) clr_mask = clr_mask | (NUM_SRC'(1) << sel_id);
        pending_nxt = (pending & ~clr_mask) | (irq_src & ~src_q);
    end

    always_ff @(posedge clk) begin
        if (rst) src_q <= '0;
        else     src_q <= irq_src;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ap_valid   <= 1'b0;
            ap_write   <= 1'b0;
            ap_addr    <= 3'd0;
            state      <= IDLE;
            irq_out_q  <= 1'b0;
            pending    <= '0;
            enable     <= '0;
            claimed_id <= 3'd0;
            eoi_err    <= 1'b0;
        end else begin
            ap_valid  <= hsel;
            ap_write  <= hwrite;
            ap_addr   <= haddr[4:2];
            state     <= state_nxt;
            irq_out_q <= (state_nxt == ASSERT);
            pending   <= pending_nxt;
            if (wr_en && (ap_addr == 3'd1)) enable <= hwdata[NUM_SRC-1:0];
            if (claim_ok) claimed_id <= sel_id;
            if (eoi_wr && !eoi_match)
                eoi_err <= 1'b1;
            else if (wr_en && (ap_addr == 3'd4) && hwdata[2])
                eoi_err <= 1'b0;
        end
    end

    always_comb begin
        hrdata = 32'd0;
        if (rd_en && !rst) begin
            case (ap_addr)
                3'd0: hrdata = {{(32-NUM_SRC){1'b0}}, pending};
                3'd1: hrdata = {{(32-NUM_SRC){1'b0}}, enable};
                3'd2: hrdata = claim_ok ? {23'd0, 1'b1, 5'd0, sel_id} : 32'd0;
                3'd4: hrdata = {29'd0, eoi_err, state};
                default: hrdata = 32'd0;
            endcase
        end
    end

    assign irq_out = irq_out_q;
    assign irq_id  = rst ? 3'd0 : sel_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hsel, hready;
    logic [2:0]  hsize;
    logic [1:0]  hresp;
    logic [7:0]  irq_src;
    logic        irq_out;
    logic [2:0]  irq_id;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int S_IDLE = 0, S_ASSERT = 1, S_SERVICE = 2;
    int m_pend, m_en, m_state, m_claimed, m_err;
    logic [31:0] rd_tmp;

    irq_ctrl #(.NUM_SRC(8)) dut (
        .clk(clk), .rst(rst), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
        .hsize(hsize), .hsel(hsel), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .irq_src(irq_src), .irq_out(irq_out), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input int v);
        for (int i = 0; i < 8; i++) if (((v >> i) & 1) != 0) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_state = S_IDLE; m_claimed = 0; m_err = 0;
    endtask

    // The CPU line follows the eligible set whenever no claim is outstanding
    task automatic settle();
        if (m_state == S_IDLE && (m_pend & m_en) != 0)      m_state = S_ASSERT;
        else if (m_state == S_ASSERT && (m_pend & m_en) == 0) m_state = S_IDLE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_irq_out"}, {31'd0, irq_out}, (m_state == S_ASSERT) ? 32'd1 : 32'd0);
        check({tag, "_irq_id"}, {29'd0, irq_id}, 32'(lowest(m_pend & m_en)));
    endtask

    task automatic addr_phase(input int off, input bit wr);
        hsel   = 1'b1;
        hwrite = wr;
        haddr  = ($urandom & 32'hFFFF_FFE3) | 32'(off << 2);
        hsize  = 3'($urandom);
        hwdata = $urandom;
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        hwrite = 1'($urandom);
        haddr  = $urandom;
    endtask

    task automatic do_write(input int off, input logic [31:0] data, input string tag);
        addr_phase(off, 1'b1);
        hwdata = data;
        @(posedge clk);
        #1;
        hwdata = $urandom;
        case (off)
            0: m_pend = m_pend & ~int'(data) & 255;
            1: m_en = int'(data) & 255;
            3: begin
                if (m_state == S_SERVICE && int'(data & 7) == m_claimed) m_state = S_IDLE;
                else m_err = 1;
            end
            4: if (data[2]) m_err = 0;
            default: ;
        endcase
        idle(2);
        settle();
        check_outputs(tag);
    endtask

    task automatic do_read(input int off, input string tag, output logic [31:0] val);
        int exp;
        int id;
        exp = 0;
        case (off)
            0: exp = m_pend;
            1: exp = m_en;
            2: if (m_state == S_ASSERT) begin
                id = lowest(m_pend & m_en);
                exp = 256 | id;
                m_pend = m_pend & ~(1 << id);
                m_claimed = id;
                m_state = S_SERVICE;
            end
            4: exp = (m_err << 2) | m_state;
            default: exp = 0;
        endcase
        addr_phase(off, 1'b0);
        val = hrdata;
        check(tag, hrdata, 32'(exp));
        idle(3);
        settle();
        check_outputs(tag);
    endtask

    task automatic pulse(input int mask, input string tag);
        irq_src = 8'(mask);
        @(posedge clk);
        #1;
        irq_src = 8'd0;
        m_pend = m_pend | (mask & 255);
        idle(1);
        settle();
        check_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0; hsize = '0; irq_src = '0;
        model_reset();
        idle(2);
        check("rst_irq_out", {31'd0, irq_out}, 32'd0);
        check("rst_irq_id", {29'd0, irq_id}, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_hready", {31'd0, hready}, 32'd1);
        check("rst_hresp", {30'd0, hresp}, 32'd0);
        rst = 1'b0;
        idle(1);
        do_read(0, "rst_pending", rd_tmp);
        do_read(1, "rst_enable", rd_tmp);
        do_read(4, "rst_status", rd_tmp);

        // basic flow
        do_write(1, 32'hFF, "basic_en");
        pulse(32'h04, "basic_pulse");
        check("basic_irq_within_2", {31'd0, irq_out}, 32'd1);
        do_read(2, "basic_claim", rd_tmp);
        check("basic_claim_val", rd_tmp, 32'h102);
        do_write(3, 32'd2, "basic_eoi");
        do_read(4, "basic_status", rd_tmp);
        check("basic_status_val", rd_tmp, 32'h0);

        // priority
        pulse(32'h22, "prio_pulse");
        do_read(2, "prio_claim1", rd_tmp);
        check("prio_claim1_val", rd_tmp, 32'h101);
        do_write(3, 32'd1, "prio_eoi1");
        check("prio_reassert", {31'd0, irq_out}, 32'd1);
        do_read(2, "prio_claim2", rd_tmp);
        check("prio_claim2_val", rd_tmp, 32'h105);
        do_write(3, 32'd5, "prio_eoi5");

        // masking
        do_write(1, 32'h00, "mask_en0");
        pulse(32'h08, "mask_pulse");
        do_read(0, "mask_pending", rd_tmp);
        check("mask_pending_val", rd_tmp, 32'h08);
        check("mask_no_irq", {31'd0, irq_out}, 32'd0);
        do_write(1, 32'h08, "mask_en8");
        check("mask_unmask_irq", {31'd0, irq_out}, 32'd1);
        do_read(2, "mask_claim", rd_tmp);
        do_write(3, 32'd3, "mask_eoi");

        // EOI error handling
        do_write(1, 32'hFF, "err_en");
        pulse(32'h10, "err_pulse");
        do_read(2, "err_claim", rd_tmp);
        check("err_claim_val", rd_tmp, 32'h104);
        do_write(3, 32'd6, "err_bad_eoi");
        do_read(4, "err_status", rd_tmp);
        check("err_status_val", rd_tmp, 32'h6);
        do_write(3, 32'd4, "err_good_eoi");
        do_read(4, "err_status2", rd_tmp);
        do_write(4, 32'h4, "err_clear");
        do_read(4, "err_status3", rd_tmp);

        // set/clear collision on source 0
        do_write(1, 32'h00, "coll_en0");
        pulse(32'h01, "coll_pre");
        addr_phase(0, 1'b1);
        hwdata  = 32'h1;
        irq_src = 8'h01;
        @(posedge clk);
        #1;
        irq_src = 8'h00;
        m_pend = (m_pend & ~1) | 1;
        idle(2);
        settle();
        do_read(0, "coll_pending", rd_tmp);
        check("coll_pending_bit0", {31'd0, rd_tmp[0]}, 32'd1);
        do_write(0, 32'hFF, "coll_cleanup");

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            int    op;
            int    off;
            op = int'($urandom_range(0, 7));
            case (op)
                0: pulse(int'($urandom & $urandom & 32'hFF), "rnd_pulse");
                1: do_write(1, $urandom, "rnd_en");
                2: do_write(0, $urandom & $urandom, "rnd_w1c");
                3: do_read(2, "rnd_claim", rd_tmp);
                4: do_write(3, ($urandom & 32'hFFFF_FFF8) |
                               32'(($urandom_range(0, 1) != 0) ? m_claimed : int'($urandom_range(0, 7))),
                            "rnd_eoi");
                5: do_read(int'($urandom_range(0, 7)), "rnd_read", rd_tmp);
                6: begin
                    off = int'($urandom_range(0, 3));
                    off = (off == 0) ? 2 : off + 4;
                    do_write(off, $urandom, "rnd_unmapped_wr");
                end
                default: do_write(4, $urandom, "rnd_status_wr");
            endcase
        end

        // reset in SERVICE with an access in flight
        do_write(0, 32'hFF, "rsv_clr");
        if (m_state == S_SERVICE) do_write(3, 32'(m_claimed), "rsv_eoi");
        do_write(1, 32'hFF, "rsv_en");
        pulse(32'h30, "rsv_pulse");
        do_read(2, "rsv_claim", rd_tmp);
        pulse(32'h10, "rsv_pulse2");
        do_read(0, "rsv_pending", rd_tmp);
        check("rsv_pending_val", rd_tmp, 32'h30);
        addr_phase(1, 1'b1);
        hwdata = 32'h0F;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check("rsv_irq_out", {31'd0, irq_out}, 32'd0);
        check("rsv_irq_id", {29'd0, irq_id}, 32'd0);
        check("rsv_hrdata", hrdata, 32'd0);
        check("rsv_hready", {31'd0, hready}, 32'd1);
        check("rsv_hresp", {30'd0, hresp}, 32'd0);
        rst = 1'b0;
        idle(1);
        do_read(0, "rsv_pending_after", rd_tmp);
        do_read(1, "rsv_enable_after", rd_tmp);
        do_read(4, "rsv_status_after", rd_tmp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
